axi_ram_fill_ctrl: RTL and testbench

//  AXI4 write-burst master that fills a word region of an axi_ram instance with a constant or incrementing

---
 rtl/axi_ram_fill_ctrl.sv | 165 ++++++++++++++++
 tb/tb_axi_ram_fill_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_fill_ctrl.sv
// AXI4 write-burst master that fills a word region with a constant or incrementing pattern.
// One burst outstanding at a time. Bursts never cross a 4 KB boundary.
module axi_ram_fill_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int ID_WIDTH      = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic [DATA_WIDTH-1:0]   cfg_data,
  input  logic                    cfg_incr,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [2:0]              debug_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload are held stable until that edge, ready may toggle freely.

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BYTES - 1));

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  incr_q;
  logic [7:0]            beat;

  logic [ADDR_WIDTH-1:0] plan_addr;
  logic [LEN_WIDTH-1:0]  plan_rem;
  logic [12:0]           bnd_words;
  logic [8:0]            plan_beats;

  assign m_axi_awid    = '0;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = '1;
  assign debug_state   = state;

  // Next burst is planned from the config inputs when starting, otherwise from the running cursor.
  always_comb begin
    plan_addr  = (state == S_IDLE) ? (cfg_addr & ALIGN_MASK) : next_addr;
    plan_rem   = (state == S_IDLE) ? cfg_len : remaining;
    bnd_words  = (13'd4096 - {1'b0, plan_addr[11:0]}) >> SIZE;
    plan_beats = (32'(plan_rem) > 32'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : 9'(plan_rem);
    if ({4'd0, plan_beats} > bnd_words) plan_beats = 9'(bnd_words);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wlast   <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_bready  <= 1'b0;
      next_addr     <= '0;
      remaining     <= '0;
      incr_q        <= 1'b0;
      beat          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            m_axi_wdata <= cfg_data;
            incr_q      <= cfg_incr;
            error       <= 1'b0;
            if (cfg_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state         <= S_AW;
              busy          <= 1'b1;
              m_axi_awvalid <= 1'b1;
              m_axi_awaddr  <= plan_addr;
              m_axi_awlen   <= 8'(plan_beats - 9'd1);
              next_addr     <= plan_addr + (ADDR_WIDTH'(plan_beats) << SIZE);
              remaining     <= plan_rem - LEN_WIDTH'(plan_beats);
            end
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wlast   <= (m_axi_awlen == 8'd0);
            beat          <= '0;
            state         <= S_W;
          end
        end
        S_W: begin
          if (m_axi_wready) begin
            // The pattern register keeps advancing past the last beat so the next burst continues it.
            m_axi_wdata <= m_axi_wdata + DATA_WIDTH'(incr_q);
            beat        <= beat + 8'd1;
            m_axi_wlast <= (beat + 8'd1 == m_axi_awlen);
            if (m_axi_wlast) begin
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              m_axi_bready <= 1'b1;
              state        <= S_B;
            end
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) error <= 1'b1;
            if (remaining == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state         <= S_AW;
              m_axi_awvalid <= 1'b1;
              m_axi_awaddr  <= plan_addr;
              m_axi_awlen   <= 8'(plan_beats - 9'd1);
              next_addr     <= plan_addr + (ADDR_WIDTH'(plan_beats) << SIZE);
              remaining     <= plan_rem - LEN_WIDTH'(plan_beats);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_fill_ctrl.sv
// Bench for axi_ram_fill_ctrl: randomized AXI slave with stalls, a word memory, and a
// reference model that derives bursts and memory contents directly from the fill rules.
module tb_axi_ram_fill_ctrl;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int MB = 16;
  localparam int LW = 16;
  localparam int WORDS = 16384;

  logic          clk, rst;
  logic          cfg_start, cfg_incr;
  logic [AW-1:0] cfg_addr;
  logic [LW-1:0] cfg_len;
  logic [DW-1:0] cfg_data;
  logic          busy, done, error;
  logic [IW-1:0] m_axi_awid;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic [2:0]    debug_state;

  axi_ram_fill_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                      .MAX_BURST_LEN(MB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .cfg_data(cfg_data), .cfg_incr(cfg_incr),
    .busy(busy), .done(done), .error(error),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .debug_state(debug_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] mem [0:WORDS-1];
  logic [23:0] exp_q[$];          // {awaddr, awlen} of each expected burst, in order
  int vectors = 0;
  int miscompares = 0;
  int cur_beat, burst_idx, err_burst, done_cnt, awv_cycles;
  logic [15:0] cur_addr;
  logic [7:0]  cur_len;
  bit in_burst, b_pending, b_fire, stall_en;

  // ---------------- AXI slave model ----------------
  initial begin
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    in_burst = 0; b_pending = 0; b_fire = 0; stall_en = 0;
    burst_idx = 0; err_burst = 0; done_cnt = 0; awv_cycles = 0; cur_beat = 0;
    cur_addr = '0; cur_len = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        in_burst = 0; b_pending = 0; b_fire = 0;
        exp_q.delete();
        continue;
      end
      if (done) done_cnt++;
      if (m_axi_awvalid) awv_cycles++;
      if (b_fire) begin
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; b_fire = 0;
      end
      m_axi_awready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_axi_wready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!m_axi_bvalid && b_pending && (!stall_en || $urandom_range(0, 1) == 1)) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (burst_idx == err_burst) ? 2'b10 : 2'b00;
        b_pending    = 0;
      end
      b_fire = m_axi_bvalid && m_axi_bready;
      if (m_axi_wvalid && m_axi_wready) begin
        vectors++;
        if (!in_burst || m_axi_wlast !== (cur_beat == int'(cur_len)) || m_axi_wstrb !== 4'hF) begin
          miscompares++;
          $display("FAIL w_beat: beat %0d wlast=%b wstrb=%h in_burst=%0d, required wlast=%b wstrb=f",
                   cur_beat, m_axi_wlast, m_axi_wstrb, in_burst, (cur_beat == int'(cur_len)));
        end
        mem[((int'(cur_addr) >> 2) + cur_beat) % WORDS] = m_axi_wdata;
        if (cur_beat == int'(cur_len)) begin
          b_pending = 1; in_burst = 0;
        end
        cur_beat++;
      end
      if (m_axi_awvalid && m_axi_awready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL aw_unexpected: addr=%h len=%0d, required no burst", m_axi_awaddr, m_axi_awlen);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          if ({m_axi_awaddr, m_axi_awlen} !== e || m_axi_awsize !== 3'd2 ||
              m_axi_awburst !== 2'b01 || m_axi_awid !== 8'd0) begin
            miscompares++;
            $display("FAIL aw_burst: addr=%h len=%0d size=%0d burst=%b id=%h, required addr=%h len=%0d size=2 burst=01 id=00",
                     m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid, e[23:8], e[7:0]);
          end
        end
        cur_addr = m_axi_awaddr; cur_len = m_axi_awlen; cur_beat = 0; in_burst = 1;
        burst_idx++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int plan_bursts(input int base, input int len);
    int a, rem, b, to_b, n;
    a = base; rem = len; n = 0;
    while (rem > 0) begin
      to_b = (4096 - (a % 4096)) / 4;
      b = rem;
      if (b > MB) b = MB;
      if (b > to_b) b = to_b;
      exp_q.push_back({16'(a), 8'(b - 1)});
      a = (a + b * 4) % 65536;
      rem -= b;
      n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] sentinel(input int i);
    return 32'h5EED_0000 ^ 32'(i * 7 + 3);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [15:0] addr, input int len, input logic [31:0] data, input bit incr);
    cfg_addr = addr; cfg_len = 16'(len); cfg_data = data; cfg_incr = incr; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_addr = 16'($urandom); cfg_len = 16'($urandom); cfg_data = $urandom; cfg_incr = 1'($urandom);
  endtask

  task automatic run_fill(input string name, input logic [15:0] addr, input int len,
                          input logic [31:0] data, input bit incr, input int eb, input bit stall);
    int base, nb, cyc, widx;
    bit exp_err;
    logic [31:0] exp_w;
    base = int'(addr) & 32'hFFFC;
    exp_q.delete();
    nb = plan_bursts(base, len);
    exp_err = (eb >= 1) && (eb <= nb);
    for (int i = -1; i <= len; i++) mem[((base >> 2) + i + WORDS) % WORDS] = sentinel(i);
    @(negedge clk);
    done_cnt = 0; awv_cycles = 0; burst_idx = 0; err_burst = eb; stall_en = stall;
    pulse_start(addr, len, data, incr);
    vectors++;
    if (len == 0) begin
      if (done !== 1'b1 || busy !== 1'b0 || m_axi_awvalid !== 1'b0 || error !== 1'b0) begin
        miscompares++;
        $display("FAIL %s start_cycle: done=%b busy=%b awvalid=%b error=%b, required 1 0 0 0",
                 name, done, busy, m_axi_awvalid, error);
      end
    end else if (m_axi_awvalid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL %s start_cycle: awvalid=%b busy=%b done=%b error=%b, required 1 1 0 0",
               name, m_axi_awvalid, busy, done, error);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      cfg_start = (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    cfg_start = 1'b0;
    vectors++;
    if (cyc >= 3000) begin
      miscompares++;
      $display("FAIL %s timeout: done not seen in %0d cycles, required done pulse", name, cyc);
    end else if (busy !== 1'b0 || error !== exp_err || m_axi_wvalid !== 1'b0 || m_axi_awvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done_cycle: busy=%b error=%b wvalid=%b awvalid=%b, required busy=0 error=%b valids=0",
               name, busy, error, m_axi_wvalid, m_axi_awvalid, exp_err);
    end
    // A start presented in the DONE cycle must be ignored.
    pulse_start(16'h2000, 7, 32'h1234_5678, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt !== 1 || busy !== 1'b0 || m_axi_awvalid !== 1'b0 || exp_q.size() != 0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_done: done_cnt=%0d busy=%b awvalid=%b done=%b bursts_left=%0d, required 1 0 0 0 0",
               name, done_cnt, busy, m_axi_awvalid, done, exp_q.size());
    end
    if (len == 0) begin
      vectors++;
      if (awv_cycles != 0) begin
        miscompares++;
        $display("FAIL %s zero_len_aw: awvalid cycles=%0d, required 0", name, awv_cycles);
      end
    end
    for (int i = -1; i <= len; i++) begin
      widx = ((base >> 2) + i + WORDS) % WORDS;
      exp_w = (i < 0 || i == len) ? sentinel(i) : (incr ? data + 32'(i) : data);
      vectors++;
      if (mem[widx] !== exp_w) begin
        miscompares++;
        $display("FAIL %s mem[%0d]: got %h, required %h", name, widx, mem[widx], exp_w);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b0; cfg_addr = '0; cfg_len = '0; cfg_data = '0; cfg_incr = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 7'd0 ||
        m_axi_awaddr !== 16'd0 || m_axi_awlen !== 8'd0 || m_axi_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: flags=%b awaddr=%h awlen=%h wdata=%h, required all zero",
               {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready},
               m_axi_awaddr, m_axi_awlen, m_axi_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_constant();
    run_fill("constant", 16'h0100, 4, 32'hA5A5_A5A5, 1'b0, 0, 1'b0);
  endtask

  task automatic test_incr_split();
    run_fill("incr_split", 16'h0000, 40, 32'h0000_0000, 1'b1, 0, 1'b0);
  endtask

  task automatic test_boundary();
    run_fill("boundary", 16'h0FF8, 4, $urandom, 1'b1, 0, 1'b0);
    run_fill("addr_wrap", 16'hFFF8, 6, 32'hFFFF_FFFE, 1'b1, 0, 1'b1);
  endtask

  task automatic test_zero_len();
    run_fill("zero_len", 16'h0300, 0, $urandom, 1'b1, 0, 1'b0);
  endtask

  task automatic test_stall_error();
    run_fill("stall_error", 16'h0400, 40, $urandom, 1'b1, 2, 1'b1);
    run_fill("error_clear", 16'h0800, 20, $urandom, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_w();
    int nb, cyc;
    exp_q.delete();
    nb = plan_bursts(16'h0200, 40);
    stall_en = 1'b0; err_burst = 0; burst_idx = 0;
    @(negedge clk);
    pulse_start(16'h0200, 40, 32'h7000_0000, 1'b1);
    cyc = 0;
    while (m_axi_wvalid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (cyc >= 100 || nb != 3 ||
        {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready} !== 7'd0 ||
        m_axi_awaddr !== 16'd0 || m_axi_awlen !== 8'd0 || m_axi_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_w: wait=%0d flags=%b awaddr=%h awlen=%h wdata=%h, required all zero",
               cyc, {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready},
               m_axi_awaddr, m_axi_awlen, m_axi_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    run_fill("after_reset", 16'h0200, 24, 32'h0BAD_F00D, 1'b1, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      run_fill("random", 16'($urandom_range(0, 65535)), $urandom_range(1, 60), $urandom,
               1'($urandom), $urandom_range(0, 4), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    run_fill("b2b_a", 16'h1FF0, 9, 32'hFFFF_FFFC, 1'b1, 1, 1'b0);
    run_fill("b2b_b", 16'h3003, 17, 32'hC0DE_0000, 1'b1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_constant();
    test_incr_split();
    test_boundary();
    test_zero_len();
    test_stall_error();
    test_reset_mid_w();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
